// File: rtl/pacman_pkg.sv
// Shared types and default timing for the pacman game blocks.
// Ghost mode encoding is consumed by the ghost movement logic.
package pacman_pkg;

   typedef enum logic [1:0] {
      MODE_SCATTER = 2'd0,
      MODE_CHASE   = 2'd1,
      MODE_FRIGHT  = 2'd2
   } ghost_mode_t;

   typedef enum logic {
      ST_SCHED  = 1'b0,
      ST_FRIGHT = 1'b1
   } ghost_state_t;

   localparam int SCATTER_T_DEF = 7;
   localparam int CHASE_T_DEF   = 20;
   localparam int FRIGHT_T_DEF  = 6;
   localparam int FLASH_T_DEF   = 2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/tick_downcounter.sv
// Loadable down counter that saturates at zero; load has priority over dec.
// at_one flags the final count so the owner can act on the expiring tick.
module tick_downcounter #(
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_value,
   output logic         o_at_one
);

   logic [W-1:0] r_value;

   always_ff @(posedge CLOCK_50) begin
      if (reset)
         r_value <= RST_VAL;
      else if (i_load)
         r_value <= i_load_val;
      else if (i_dec && (r_value != '0))
         r_value <= r_value - W'(1);
   end

   assign o_value  = r_value;
   assign o_at_one = (r_value == W'(1));

endmodule

// File: rtl/ghost_mode_timer.sv
// Ghost behaviour mode: scatter/chase schedule with a frightened overlay.
// All outputs are registered; next values are built in one combinational block.
module ghost_mode_timer
   import pacman_pkg::*;
#(
   parameter int SCATTER_T  = SCATTER_T_DEF,
   parameter int CHASE_T    = CHASE_T_DEF,
   parameter int FRIGHT_T   = FRIGHT_T_DEF,
   parameter int FLASH_T    = FLASH_T_DEF,
   parameter int NUM_PHASES = 7,
   parameter int CW         = $clog2(max3(SCATTER_T, CHASE_T, FRIGHT_T) + 1),
   parameter int PW         = $clog2(NUM_PHASES + 1)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          tick,
   input  logic          enable,
   input  logic          power_pellet,
   output logic [1:0]    mode,
   output logic          flash,
   output logic          reverse,
   output logic [PW-1:0] phase,
   output logic [CW-1:0] fright_left
);

   ghost_state_t  r_state, w_state_nxt;
   ghost_mode_t   r_mode, w_mode_nxt;
   logic          r_flash, w_flash_nxt;
   logic          r_reverse, w_rev_nxt;
   logic [PW-1:0] r_phase, w_phase_nxt;

   logic          w_evt, w_pel, w_last;
   logic          w_sch_load, w_sch_dec, w_sch_at_one;
   logic [CW-1:0] w_sch_load_val, w_sch_val;
   logic          w_fr_load, w_fr_dec, w_fr_at_one;
   logic [CW-1:0] w_fr_val, w_fr_nxt;

   assign w_evt  = tick & enable;
   assign w_pel  = power_pellet & enable;
   assign w_last = (r_phase == PW'(NUM_PHASES));

   tick_downcounter #(.W(CW), .RST_VAL(CW'(SCATTER_T))) u_sched_cnt (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .i_load     (w_sch_load),
      .i_load_val (w_sch_load_val),
      .i_dec      (w_sch_dec),
      .o_value    (w_sch_val),
      .o_at_one   (w_sch_at_one)
   );

   tick_downcounter #(.W(CW), .RST_VAL('0)) u_fright_cnt (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .i_load     (w_fr_load),
      .i_load_val (CW'(FRIGHT_T)),
      .i_dec      (w_fr_dec),
      .o_value    (w_fr_val),
      .o_at_one   (w_fr_at_one)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state   <= ST_SCHED;
         r_mode    <= MODE_SCATTER;
         r_flash   <= 1'b0;
         r_reverse <= 1'b0;
         r_phase   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_mode    <= w_mode_nxt;
         r_flash   <= w_flash_nxt;
         r_reverse <= w_rev_nxt;
         r_phase   <= w_phase_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_phase_nxt    = r_phase;
      w_rev_nxt      = 1'b0;
      w_sch_load     = 1'b0;
      w_sch_load_val = '0;
      w_sch_dec      = 1'b0;
      w_fr_load      = 1'b0;
      w_fr_dec       = 1'b0;

      case (r_state)
         ST_SCHED: begin
            // A pellet consumes the cycle: the schedule neither counts nor advances.
            if (w_pel) begin
               w_state_nxt = ST_FRIGHT;
               w_fr_load   = 1'b1;
               w_rev_nxt   = 1'b1;
            end else if (w_evt && !w_last) begin
               if (w_sch_at_one) begin
                  w_phase_nxt = r_phase + PW'(1);
                  w_sch_load  = 1'b1;
                  w_rev_nxt   = 1'b1;
                  if (w_phase_nxt == PW'(NUM_PHASES))
                     w_sch_load_val = '0;
                  else if (w_phase_nxt[0])
                     w_sch_load_val = CW'(CHASE_T);
                  else
                     w_sch_load_val = CW'(SCATTER_T);
               end else if (w_sch_val != '0) begin
                  w_sch_dec = 1'b1;
               end
            end
         end
         ST_FRIGHT: begin
            if (w_pel) begin
               w_fr_load = 1'b1;
            end else if (w_evt) begin
               w_fr_dec = 1'b1;
               if (w_fr_at_one)
                  w_state_nxt = ST_SCHED;
            end
         end
         default: w_state_nxt = ST_SCHED;
      endcase

      // Mirror the fright counter's next value so flash lines up with it.
      if (w_fr_load)
         w_fr_nxt = CW'(FRIGHT_T);
      else if (w_fr_dec && (w_fr_val != '0))
         w_fr_nxt = w_fr_val - CW'(1);
      else
         w_fr_nxt = w_fr_val;

      if (w_state_nxt == ST_FRIGHT)
         w_mode_nxt = MODE_FRIGHT;
      else if ((w_phase_nxt == PW'(NUM_PHASES)) || w_phase_nxt[0])
         w_mode_nxt = MODE_CHASE;
      else
         w_mode_nxt = MODE_SCATTER;

      w_flash_nxt = (w_state_nxt == ST_FRIGHT) && (w_fr_nxt <= CW'(FLASH_T));
   end

   assign mode        = r_mode;
   assign flash       = r_flash;
   assign reverse     = r_reverse;
   assign phase       = r_phase;
   assign fright_left = w_fr_val;

endmodule
